in_channel: RTL and testbench

IN_CHANNEL -- requirements
Module: in_channel

---
 rtl/in_channel.sv | 96 +++++++++
 tb/tb_in_channel.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/in_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : in_channel                                                   |
// | Description : Input channel FIFO feeding the program's "in" / "inSize"     |
// |               instructions. Optional sticky underflow flag is enabled by    |
// |               defining IN_CHANNEL_UNDERFLOW_EN.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module in_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [MemoryElementWidth-1:0] in_data,
  output logic                          in_ready,
  input  logic                          pop,
  output logic [MemoryElementWidth-1:0] pop_data,
  output logic [MemoryElementWidth-1:0] size,
  output logic                          underflow
);

  localparam int PTR_W = (NIn > 1) ? $clog2(NIn) : 1;

  localparam logic [PTR_W-1:0]              c_ptr_last = PTR_W'(NIn - 1);
  localparam logic [PTR_W-1:0]              c_ptr_one  = PTR_W'(1);
  localparam logic [MemoryElementWidth-1:0] c_nin      = MemoryElementWidth'(NIn);
  localparam logic [MemoryElementWidth-1:0] c_cnt_one  = MemoryElementWidth'(1);

  logic [MemoryElementWidth-1:0] r_mem [NIn];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [MemoryElementWidth-1:0] r_count;
  logic [MemoryElementWidth-1:0] r_pop_data;

  logic w_push;
  logic w_pop;
  logic w_empty;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count < c_nin);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = pop && !w_empty;

  assign pop_data = r_pop_data;
  assign size     = r_count;

  // Storage is not reset; stale entries are unreachable once count is zero.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pop_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_pop_data <= r_mem[r_rd_ptr];
        r_rd_ptr   <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

`ifdef IN_CHANNEL_UNDERFLOW_EN
  logic r_underflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (pop && w_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign underflow = r_underflow;
`else
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_in_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_in_channel                                                |
// | Description : Scoreboard bench for in_channel: directed scenarios followed  |
// |               by random traffic, checked against a queue-based model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_in_channel;

  localparam int W   = 12;
  localparam int NIN = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         pop;
  logic [W-1:0] pop_data;
  logic [W-1:0] size;
  logic         underflow;

  in_channel #(
    .MemoryElementWidth (W),
    .NIn                (NIN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pop       (pop),
    .pop_data  (pop_data),
    .size      (size),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] pd;
    logic [W-1:0] sz;
    logic         rdy;
    logic         uf;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] model_q [$];
  logic [W-1:0] model_last;
  logic         model_uf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a plain word queue plus last-popped value and sticky flag.
  task automatic model_step(input logic r, input logic v, input logic [W-1:0] d, input logic p);
    int   pre;
    exp_t e;
    if (r) begin
      model_q.delete();
      model_last = '0;
      model_uf   = 1'b0;
    end else begin
      pre = model_q.size();
      if (p && pre != 0) model_last = model_q.pop_front();
`ifdef IN_CHANNEL_UNDERFLOW_EN
      if (p && pre == 0) model_uf = 1'b1;
`endif
      if (v && pre < NIN) model_q.push_back(d);
    end
    e.pd  = model_last;
    e.sz  = W'(model_q.size());
    e.rdy = (model_q.size() < NIN);
    e.uf  = model_uf;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input logic p);
    reset    = r;
    in_valid = v;
    in_data  = d;
    pop      = p;
    model_step(r, v, d, p);
    @(posedge clock);
    #1;
  endtask

  // Monitor: each expectation describes DUT outputs after the following rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pop_data",  pop_data,           e.pd);
      chk("size",      size,               e.sz);
      chk("in_ready",  W'(in_ready),       W'(e.rdy));
      chk("underflow", W'(underflow),      W'(e.uf));
    end
  end

  initial begin
    model_last = '0;
    model_uf   = 1'b0;

    // Fill to full, then drain in order
    cyc(1, 0, 0, 0);
    cyc(0, 1, 33, 0);
    cyc(0, 1, 22, 0);
    cyc(0, 1, 11, 0);
    cyc(0, 1, 99, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Pointer wrap with non-power-of-two depth
    cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 3, 0);
    cyc(0, 1, 4, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Simultaneous push and pop, non-empty then empty
    cyc(0, 1, 7, 0);
    cyc(0, 1, 9, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 5, 1);
    cyc(0, 0, 0, 1);

    // Pop on empty
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Reset mid-operation with a competing push
    cyc(0, 1, 33, 0);
    cyc(0, 1, 22, 0);
    cyc(1, 1, 44, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(9) < 6),
          W'($urandom), ($urandom_range(1) == 1));
    end
    cyc(0, 0, 0, 0);

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
